// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared types and constants for the load/store unit.
//   lsu_state_t     : FSM states IDLE / ACCESS / MERGE / RESP
//   LSU_WORD_BYTES  : bytes per data word (4)
//   LSU_LANE_W      : width of a byte-lane select
//   LSU_DATA_W      : data word width in bits (32)
//   LANE_B0..B3     : little-endian lane selects (lane 0 = bits [7:0])
//   word_misaligned : true for a word access whose byte offset is non-zero
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  localparam int LSU_WORD_BYTES = 4;
  localparam int LSU_LANE_W     = 2;
  localparam int LSU_DATA_W     = LSU_WORD_BYTES * 8;

  localparam logic [LSU_LANE_W-1:0] LANE_B0 = 2'd0;
  localparam logic [LSU_LANE_W-1:0] LANE_B1 = 2'd1;
  localparam logic [LSU_LANE_W-1:0] LANE_B2 = 2'd2;
  localparam logic [LSU_LANE_W-1:0] LANE_B3 = 2'd3;

  function automatic logic word_misaligned(input logic byte_acc,
                                           input logic [LSU_LANE_W-1:0] lane);
    return !byte_acc && (lane != LANE_B0);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane -- combinational byte-lane helper.
//   word_in   in  : source word
//   lane      in  : byte lane (little-endian, lane 0 = bits [7:0])
//   byte_in   in  : byte to insert for the merge path
//   ext_out   out : selected lane of word_in, zero-extended
//   merge_out out : word_in with the selected lane replaced by byte_in
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [LSU_DATA_W-1:0] word_in,
  input  logic [LSU_LANE_W-1:0] lane,
  input  logic [7:0]            byte_in,
  output logic [LSU_DATA_W-1:0] ext_out,
  output logic [LSU_DATA_W-1:0] merge_out
);

  logic [7:0] lane_byte;

  assign lane_byte = word_in[{lane, 3'b000} +: 8];
  assign ext_out   = {{(LSU_DATA_W-8){1'b0}}, lane_byte};

  genvar gi;
  generate
    for (gi = 0; gi < LSU_WORD_BYTES; gi++) begin : g_lane
      assign merge_out[gi*8 +: 8] = (lane == LSU_LANE_W'(gi)) ? byte_in
                                                               : word_in[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- memory-access stage between execute and data_mem.
// Takes one load/store at a time over a valid/ready request, performs word
// or byte accesses (byte stores by read-modify-write) and reports completion
// with a one-cycle resp_valid pulse.
//   clk, reset              : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (ready only when idle)
//   req_write, req_byte     : store/load, byte/word
//   req_addr, req_wdata     : byte address, store data (byte store uses [7:0])
//   resp_valid, resp_rdata, resp_err : completion pulse, load data, error
//   mem_wen, mem_addr, mem_wdata, mem_rdata : data_mem port (comb. read)
// Build option: define LSU_RANGE_CHECK_EN to reject any address whose bits
// above the memory range are non-zero; otherwise such addresses wrap.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t              state_reg, state_next;
  logic                    write_reg, byte_reg, err_reg;
  logic [ADDR_W-1:0]       idx_reg;
  logic [LSU_LANE_W-1:0]   lane_reg;
  logic [DATA_W-1:0]       wdata_reg, cap_reg, rdata_reg;
  logic                    wen_raw;
  logic                    req_err;
  logic [DATA_W-1:0]       lane_word, lane_ext, lane_merge;

`ifdef LSU_RANGE_CHECK_EN
  assign req_err = word_misaligned(req_byte, req_addr[1:0]) ||
                   (|req_addr[31:ADDR_W+2]);
`else
  // Upper address bits deliberately wrap; they take no part in the access.
  logic unused_upper;
  assign unused_upper = |req_addr[31:ADDR_W+2];
  assign req_err      = word_misaligned(req_byte, req_addr[1:0]);
`endif

  // One lane helper serves both paths: extract from the live read data in
  // ACCESS, merge into the captured word in MERGE.
  assign lane_word = (state_reg == MERGE) ? cap_reg : mem_rdata;

  lsu_byte_lane u_byte_lane (
    .word_in   (lane_word),
    .lane      (lane_reg),
    .byte_in   (wdata_reg[7:0]),
    .ext_out   (lane_ext),
    .merge_out (lane_merge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      write_reg <= 1'b0;
      byte_reg  <= 1'b0;
      idx_reg   <= '0;
      lane_reg  <= '0;
      wdata_reg <= '0;
      cap_reg   <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            write_reg <= req_write;
            byte_reg  <= req_byte;
            idx_reg   <= req_addr[ADDR_W+1:2];
            lane_reg  <= req_addr[1:0];
            wdata_reg <= req_wdata;
            if (req_err) begin
              rdata_reg <= '0;
              err_reg   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (!write_reg) begin
            rdata_reg <= byte_reg ? lane_ext : mem_rdata;
            err_reg   <= 1'b0;
          end else if (!byte_reg) begin
            rdata_reg <= '0;
            err_reg   <= 1'b0;
          end else begin
            cap_reg   <= mem_rdata;
          end
        end
        MERGE: begin
          rdata_reg <= '0;
          err_reg   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    wen_raw    = 1'b0;
    mem_wdata  = '0;
    case (state_reg)
      IDLE: begin
        if (req_valid) state_next = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (write_reg && byte_reg) begin
          state_next = MERGE;
        end else begin
          state_next = RESP;
          if (write_reg) begin
            wen_raw   = 1'b1;
            mem_wdata = wdata_reg;
          end
        end
      end
      MERGE: begin
        wen_raw    = 1'b1;
        mem_wdata  = lane_merge;
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A reset landing mid-operation must not let the pending write through.
  assign mem_wen    = wen_raw & ~reset;
  assign mem_addr   = idx_reg;
  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit -- self-checking bench for load_store_unit.
// Directed table of requests, a reset-during-MERGE sequence and randomized
// requests checked against a word-array reference model. Honours
// LSU_RANGE_CHECK_EN when the bench is built with it defined.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_write, req_byte;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err, mem_wen;
  logic [31:0]       resp_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_byte   (req_byte),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // data_mem: combinational read, write on rising edge.
  logic [31:0] mem [DEPTH];
  logic        mem_init;

  function automatic logic [31:0] init_val(input int i);
    return (i == 13) ? 32'h1122_3344 : (32'hC0DE_0000 | i);
  endfunction

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s: got %h, required %h", name, act, exp);
    end
  endtask

  // Behavioural model: what a request should produce, and its effect on memory.
  task automatic model_req(input logic w, input logic b, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic er, output int lat, output int nwr,
                           output logic [31:0] wword, output int idx);
    int lane;
    idx   = int'(a[ADDR_W+1:2]);
    lane  = int'(a[1:0]);
    er    = (!b && lane != 0);
`ifdef LSU_RANGE_CHECK_EN
    if ((a >> (ADDR_W + 2)) != 0) er = 1'b1;
`endif
    rd = 32'h0; nwr = 0; wword = 32'h0;
    if (er) begin
      lat = 1;
    end else if (!w) begin
      lat = 2;
      rd  = b ? ((ref_mem[idx] >> (8 * lane)) & 32'hFF) : ref_mem[idx];
    end else begin
      nwr = 1;
      if (b) begin
        lat   = 3;
        wword = (ref_mem[idx] & ~(32'hFF << (8 * lane))) | ({24'h0, wd[7:0]} << (8 * lane));
      end else begin
        lat   = 2;
        wword = wd;
      end
      ref_mem[idx] = wword;
    end
  endtask

  task automatic run_txn(input string tag, input logic w, input logic b,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] e_rd, input logic e_err, input int e_lat,
                         input int e_nwr, input logic [31:0] e_wword, input int e_idx);
    int lat, nresp, nwr, nbusy, cyc;
    logic [31:0] rd, wword;
    logic [ADDR_W-1:0] widx, a1;
    logic er;
    lat = 0; nresp = 0; nwr = 0; nbusy = 0;
    rd = 32'hDEAD_BEEF; er = 1'b0; wword = 32'h0; widx = '0; a1 = '0;
    @(negedge clk);
    req_write = w; req_byte = b; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " ready_wait"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_write = 1'($urandom);
    req_byte  = 1'($urandom);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) a1 = mem_addr;
      if (mem_wen) begin
        nwr++;
        widx  = mem_addr;
        wword = mem_wdata;
      end
      if (resp_valid) begin
        nresp++;
        if (lat == 0) begin
          lat = k;
          rd  = resp_rdata;
          er  = resp_err;
        end
      end
      if (lat == 0 && req_ready) nbusy++;
      if (lat != 0 && k > lat) break;
    end
    $display("txn %0s w=%0d b=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d writes=%0d",
             tag, w, b, a, wd, rd, er, lat, nwr);
    check({tag, " latency"}, lat, e_lat);
    check({tag, " resp_pulses"}, nresp, 1);
    check({tag, " rdata"}, rd, e_rd);
    check({tag, " err"}, {31'h0, er}, {31'h0, e_err});
    check({tag, " writes"}, nwr, e_nwr);
    check({tag, " busy_ready"}, nbusy, 0);
    check({tag, " ready_after"}, {31'h0, req_ready}, 32'h1);
    if (e_lat > 1) check({tag, " access_addr"}, {26'h0, a1}, e_idx);
    if (e_nwr > 0) begin
      check({tag, " write_addr"}, {26'h0, widx}, e_idx);
      check({tag, " write_data"}, wword, e_wword);
    end
  endtask

  typedef struct {
    logic        w;
    logic        b;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;
    int          e_nwr;
    logic [31:0] e_wword;
    int          e_idx;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] m_rd, m_ww, a, wd;
    logic        m_er, w, b;
    int          m_lat, m_nwr, m_idx;

    vecs[0]  = '{1'b1, 1'b0, 32'h30, 32'hF0F0_F0F0, 32'h0, 1'b0, 2, 1, 32'hF0F0_F0F0, 12};
    vecs[1]  = '{1'b0, 1'b0, 32'h30, 32'h0, 32'hF0F0_F0F0, 1'b0, 2, 0, 32'h0, 12};
    vecs[2]  = '{1'b1, 1'b1, 32'h36, 32'h0000_00AA, 32'h0, 1'b0, 3, 1, 32'h11AA_3344, 13};
    vecs[3]  = '{1'b0, 1'b1, 32'h37, 32'h0, 32'h0000_0011, 1'b0, 2, 0, 32'h0, 13};
    vecs[4]  = '{1'b0, 1'b0, 32'h3D, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 15};
`ifdef LSU_RANGE_CHECK_EN
    vecs[5]  = '{1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 0};
`else
    vecs[5]  = '{1'b0, 1'b0, 32'h100, 32'h0, 32'hC0DE_0000, 1'b0, 2, 0, 32'h0, 0};
`endif
    vecs[6]  = '{1'b0, 1'b1, 32'h34, 32'h0, 32'h0000_0044, 1'b0, 2, 0, 32'h0, 13};
    vecs[7]  = '{1'b1, 1'b0, 32'h32, 32'h0000_DEAD, 32'h0, 1'b1, 1, 0, 32'h0, 12};
    vecs[8]  = '{1'b1, 1'b0, 32'h40, 32'h1234_5678, 32'h0, 1'b0, 2, 1, 32'h1234_5678, 16};
    vecs[9]  = '{1'b0, 1'b1, 32'h42, 32'h0, 32'h0000_0034, 1'b0, 2, 0, 32'h0, 16};
    vecs[10] = '{1'b1, 1'b1, 32'h43, 32'h7777_77EE, 32'h0, 1'b0, 3, 1, 32'hEE34_5678, 16};
    vecs[11] = '{1'b0, 1'b0, 32'h40, 32'h0, 32'hEE34_5678, 1'b0, 2, 0, 32'h0, 16};
    vecs[12] = '{1'b0, 1'b1, 32'h3B, 32'h0, 32'h0000_00C0, 1'b0, 2, 0, 32'h0, 14};

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

    reset = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_byte = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_init = 1'b0;
    #1;
    check("reset req_ready", {31'h0, req_ready}, 32'h1);
    check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset resp_err", {31'h0, resp_err}, 32'h0);
    check("reset mem_wen", {31'h0, mem_wen}, 32'h0);
    check("reset mem_addr", {26'h0, mem_addr}, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      model_req(vecs[i].w, vecs[i].b, vecs[i].addr, vecs[i].wdata,
                m_rd, m_er, m_lat, m_nwr, m_ww, m_idx);
      run_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].b, vecs[i].addr, vecs[i].wdata,
              vecs[i].e_rd, vecs[i].e_err, vecs[i].e_lat, vecs[i].e_nwr,
              vecs[i].e_wword, vecs[i].e_idx);
    end
    check("mem12 after misaligned store", mem[12], 32'hF0F0_F0F0);

    // Reset during the MERGE cycle of a byte store to word 63.
    @(negedge clk);
    req_write = 1'b1; req_byte = 1'b1; req_addr = 32'hFC; req_wdata = 32'h5A; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_seq access_addr", {26'h0, mem_addr}, 32'd63);
    @(negedge clk);
    check("rst_seq merge_wen", {31'h0, mem_wen}, 32'h1);
    check("rst_seq merge_wdata", mem_wdata, (ref_mem[63] & ~32'hFF) | 32'h5A);
    reset = 1'b1;
    #1;
    check("rst_seq wen_gated", {31'h0, mem_wen}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("txn rst_seq STRB addr=000000fc reset in MERGE -> word63=%h", mem[63]);
    check("rst_seq word63", mem[63], ref_mem[63]);
    check("rst_seq req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_seq resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_seq resp_rdata", resp_rdata, 32'h0);
    check("rst_seq resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_seq mem_wen", {31'h0, mem_wen}, 32'h0);
    check("rst_seq mem_addr", {26'h0, mem_addr}, 32'h0);
    check("rst_seq mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    check("rst_seq no_late_resp", {31'h0, resp_valid}, 32'h0);

    // Randomized requests against the reference model.
    for (int n = 0; n < 150; n++) begin
      w  = 1'($urandom);
      b  = 1'($urandom);
      a  = $urandom;
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) a[31:8] = 24'h0;
      if (!b && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      model_req(w, b, a, wd, m_rd, m_er, m_lat, m_nwr, m_ww, m_idx);
      run_txn($sformatf("rnd%0d", n), w, b, a, wd, m_rd, m_er, m_lat, m_nwr, m_ww, m_idx);
    end

    for (int i = 0; i < DEPTH; i++) check($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between the execute stage and data_mem.
- Accepts one load or store request at a time, with a byte address from the ALU.
- Converts the byte address to a data_mem word index.
- Performs word and byte accesses; byte stores use read-modify-write.
- Returns load data to writeback through a valid/ready request and a single-cycle response pulse.

Parameters:
- ADDR_W, 6, data_mem word-index width (memory depth = 2**ADDR_W words).
- DATA_W, 32, data word width; must be 32.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and accepting.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access (LDRB/STRB), 0 = word.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; bits [7:0] used for a byte store.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; zero for stores and errors.
- resp_err  out  1  access error, valid with resp_valid.
- mem_wen  out  1  data_mem write enable.
- mem_addr  out  ADDR_W  data_mem word index.
- mem_wdata  out  32  data_mem write data.
- mem_rdata  in  32  data_mem read data (combinational read of mem_addr).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Memory model: data_mem reads combinationally; it writes at the clk rising edge when mem_wen=1.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wen=0, mem_addr=0, mem_wdata=0. All request latches are cleared.
- Addressing:
  - word index = req_addr[ADDR_W+1:2]; upper bits are ignored (wrap-around).
  - byte lane = req_addr[1:0], little-endian; lane 0 = bits [7:0].
- FSM states: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/byte/addr/wdata, then go to ACCESS.
  - A misaligned word access (byte=0 and addr[1:0]!=0) goes directly to RESP with err=1 and makes no memory access.
- ACCESS: drive mem_addr from the latch.
  - Load word: capture mem_rdata, go to RESP.
  - Load byte: capture the selected lane, zero-extended, go to RESP.
  - Store word: mem_wen=1, mem_wdata=wdata, go to RESP.
  - Store byte: capture mem_rdata, go to MERGE.
- MERGE: mem_wen=1, mem_wdata = captured word with the selected lane replaced by wdata[7:0]; go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in every state except IDLE.
- Latency from the acceptance edge to the resp_valid cycle:
  - loads and word stores: 2 cycles.
  - byte stores: 3 cycles.
  - errors: 1 cycle.
- mem_wen is gated by ~reset. If reset is asserted during ACCESS or MERGE, no write happens at that edge, and the partial operation is abandoned without a response.
- A request that is held (req_valid=1) during a busy period is not accepted until req_ready=1.
- resp_rdata holds its value until the next response.

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined: any request with req_addr[31:ADDR_W+2] != 0 skips memory and responds after 1 cycle with resp_err=1 and resp_rdata=0.
- Undefined: upper address bits are ignored and the access wraps into the 2**ADDR_W-word memory.

Decomposition:
- Package lsu_pkg: lsu_state_t enum (IDLE/ACCESS/MERGE/RESP), LSU_WORD_BYTES=4, lane-select constants.
- One sub-module, lsu_byte_lane: combinational byte extract (word, lane → zero-extended byte) and byte merge (word, lane, byte → word). It is instantiated once, and both paths are used.

Test Plan:
- Word store then load:
  - Stimulus: store addr=0x30, data=0xF0F0F0F0.
  - Required: mem_wen=1 with mem_addr=12 one cycle after acceptance, then resp_valid.
  - Follow-up: a load of 0x30 returns 0xF0F0F0F0 two cycles after acceptance.
- Byte store read-modify-write:
  - Stimulus: word 13 = 0x11223344; STRB addr=0x36, data=0xAA.
  - Required: mem_wdata=0x11AA3344 in the MERGE cycle.
- Byte load:
  - Stimulus: LDRB addr=0x37 with word 13 = 0x11AA3344.
  - Required: resp_rdata=0x00000011.
- Misaligned word access:
  - Stimulus: load addr=0x3D.
  - Required: resp_err=1, resp_rdata=0, no mem_wen; resp_valid one cycle after acceptance.
- Reset mid-operation:
  - Stimulus: reset asserted in the MERGE cycle of STRB addr=0xFC.
  - Required: mem_wen=0, word 63 unchanged, all outputs return to reset values, req_ready=1 next cycle.
- Wrap / range check:
  - Stimulus: load addr=0x100.
  - Required without LSU_RANGE_CHECK_EN: mem_addr=0, data returned.
  - Required with LSU_RANGE_CHECK_EN: resp_err=1.
